morse_sequencer: RTL and testbench

Sequences a buffered stream of ASCII characters into the Morse blinker. Accepts characters from a host through a valid/full handshake into an 8-entry FIFO and encodes each one to a 20-bit on/off unit pattern. Drives the blinker's load, s3 and s7 inputs, and inserts the standard inter-character (3-unit) and inter-word (7-unit) gaps. Runs on the system clock and is paced by a one-cycle unit strobe from the shared clock divider.

---
 rtl/morse_sequencer_pkg.sv | 56 +++++
 rtl/morse_sequencer_if.sv | 27 ++
 rtl/morse_sequencer_encoder.sv | 62 ++++++
 rtl/morse_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_morse_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_sequencer_pkg.sv
// Shared types, widths and helpers for the Morse sequencer: FSM state encoding,
// pattern geometry, default gaps, ASCII ranges and the symbol-to-unit expansion.
package morse_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int PATTERN_W    = 20;
  localparam int LEN_W        = 5;
  localparam int GAP_CHAR_DEF = 3;
  localparam int GAP_WORD_DEF = 7;

  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if ((c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z)) begin
      return c - ASCII_CASE_OFS;
    end else begin
      return c;
    end
  endfunction

  // Expands n symbols (sym[4] first, 1 = dash) into {len, left-justified pattern}.
  function automatic logic [LEN_W+PATTERN_W-1:0] build_pattern(input logic [2:0] n,
                                                               input logic [4:0] sym);
    logic [PATTERN_W-1:0] acc;
    logic [LEN_W-1:0]     len;
    acc = '0;
    len = '0;
    for (int i = 0; i < 5; i++) begin
      if (3'(i) < n) begin
        if (i != 0) begin
          acc = {acc[PATTERN_W-2:0], 1'b0};
          len = len + 5'd1;
        end
        if (sym[4-i]) begin
          acc = {acc[PATTERN_W-4:0], 3'b111};
          len = len + 5'd3;
        end else begin
          acc = {acc[PATTERN_W-2:0], 1'b1};
          len = len + 5'd1;
        end
      end
    end
    acc = acc << (LEN_W'(PATTERN_W) - len);
    return {len, acc};
  endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Host write port and blinker control bundle of the Morse sequencer.
interface morse_sequencer_if;
  import morse_sequencer_pkg::*;

  logic                 i_tick;
  logic [7:0]           i_char;
  logic                 i_valid;
  logic                 o_full;
  logic                 i_ready;
  logic [PATTERN_W-1:0] o_morse_code;
  logic                 o_read;
  logic                 o_s3;
  logic                 o_s7;
  logic                 o_busy;
  logic                 o_bad_char;

  modport master (
    output i_tick, i_char, i_valid, i_ready,
    input  o_full, o_morse_code, o_read, o_s3, o_s7, o_busy, o_bad_char
  );

  modport slave (
    input  i_tick, i_char, i_valid, i_ready,
    output o_full, o_morse_code, o_read, o_s3, o_s7, o_busy, o_bad_char
  );

endinterface

// File: rtl/morse_sequencer_encoder.sv
// Combinational ASCII to Morse unit-pattern encoder; letters are case-folded,
// anything other than A-Z / 0-9 reports valid = 0.
module morse_encoder
  import morse_sequencer_pkg::*;
(
  input  logic [7:0]           ascii,
  output logic [PATTERN_W-1:0] pattern,
  output logic [LEN_W-1:0]     len,
  output logic                 valid
);

  logic [7:0] up_s;
  logic [7:0] code_s;

  // Symbol table as {symbol count, symbols left-justified with 1 = dash}
  always_comb begin
    up_s   = to_upper(ascii);
    code_s = 8'd0;
    case (up_s)
      8'h41:   code_s = {3'd2, 5'b01000};
      8'h42:   code_s = {3'd4, 5'b10000};
      8'h43:   code_s = {3'd4, 5'b10100};
      8'h44:   code_s = {3'd3, 5'b10000};
      8'h45:   code_s = {3'd1, 5'b00000};
      8'h46:   code_s = {3'd4, 5'b00100};
      8'h47:   code_s = {3'd3, 5'b11000};
      8'h48:   code_s = {3'd4, 5'b00000};
      8'h49:   code_s = {3'd2, 5'b00000};
      8'h4A:   code_s = {3'd4, 5'b01110};
      8'h4B:   code_s = {3'd3, 5'b10100};
      8'h4C:   code_s = {3'd4, 5'b01000};
      8'h4D:   code_s = {3'd2, 5'b11000};
      8'h4E:   code_s = {3'd2, 5'b10000};
      8'h4F:   code_s = {3'd3, 5'b11100};
      8'h50:   code_s = {3'd4, 5'b01100};
      8'h51:   code_s = {3'd4, 5'b11010};
      8'h52:   code_s = {3'd3, 5'b01000};
      8'h53:   code_s = {3'd3, 5'b00000};
      8'h54:   code_s = {3'd1, 5'b10000};
      8'h55:   code_s = {3'd3, 5'b00100};
      8'h56:   code_s = {3'd4, 5'b00010};
      8'h57:   code_s = {3'd3, 5'b01100};
      8'h58:   code_s = {3'd4, 5'b10010};
      8'h59:   code_s = {3'd4, 5'b10110};
      8'h5A:   code_s = {3'd4, 5'b11000};
      8'h30:   code_s = {3'd5, 5'b11111};
      8'h31:   code_s = {3'd5, 5'b01111};
      8'h32:   code_s = {3'd5, 5'b00111};
      8'h33:   code_s = {3'd5, 5'b00011};
      8'h34:   code_s = {3'd5, 5'b00001};
      8'h35:   code_s = {3'd5, 5'b00000};
      8'h36:   code_s = {3'd5, 5'b10000};
      8'h37:   code_s = {3'd5, 5'b11000};
      8'h38:   code_s = {3'd5, 5'b11100};
      8'h39:   code_s = {3'd5, 5'b11110};
      default: code_s = 8'd0;
    endcase
    {len, pattern} = build_pattern(code_s[7:5], code_s[4:0]);
    valid          = (code_s[7:5] != 3'd0);
  end

endmodule

// File: rtl/morse_sequencer.sv
// Buffers host characters in a small FIFO and plays each one to the blinker as a
// load strobe followed by its unit count and the inter-character / inter-word gaps.
module morse_sequencer
  import morse_sequencer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int GAP_CHAR = GAP_CHAR_DEF,
  parameter int GAP_WORD = GAP_WORD_DEF
) (
  input logic               i_clk,
  input logic               i_rst,
  morse_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;

  state_t               state_r, state_nxt_s;
  logic [LEN_W-1:0]     unit_cnt_r, unit_cnt_nxt_s;
  logic [LEN_W-1:0]     gap_cnt_r, gap_cnt_nxt_s;
  logic                 s3_r, s3_nxt_s;
  logic                 s7_r, s7_nxt_s;
  logic                 bad_r, bad_nxt_s;
  logic                 load_s;
  logic [PATTERN_W-1:0] pattern_r;
  logic [LEN_W-1:0]     len_r;

  logic [PATTERN_W-1:0] enc_pattern_s;
  logic [LEN_W-1:0]     enc_len_s;
  logic                 enc_valid_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == '0);
  assign push_s  = bus.i_valid && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  morse_encoder u_encoder (
    .ascii   (head_s),
    .pattern (enc_pattern_s),
    .len     (enc_len_s),
    .valid   (enc_valid_s)
  );

  // FIFO storage; contents are not reset, the pointers define what is live
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.i_char;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Next-state logic; every transition is gated by the unit strobe
  always_comb begin
    state_nxt_s    = state_r;
    unit_cnt_nxt_s = unit_cnt_r;
    gap_cnt_nxt_s  = gap_cnt_r;
    s3_nxt_s       = s3_r;
    s7_nxt_s       = s7_r;
    bad_nxt_s      = 1'b0;
    pop_s          = 1'b0;
    load_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && bus.i_tick && bus.i_ready) begin
          pop_s = 1'b1;
          if (enc_valid_s) begin
            load_s      = 1'b1;
            state_nxt_s = ST_LOAD;
          end else if (head_s == ASCII_SPACE) begin
            gap_cnt_nxt_s = LEN_W'(GAP_WORD - GAP_CHAR);
            s7_nxt_s      = 1'b1;
            state_nxt_s   = ST_GAP;
          end else begin
            bad_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.i_tick) begin
          unit_cnt_nxt_s = len_r;
          state_nxt_s    = ST_SEND;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (bus.i_tick && (unit_cnt_r <= 5'd1)) begin
          unit_cnt_nxt_s = 5'd0;
          gap_cnt_nxt_s  = LEN_W'(GAP_CHAR);
          s3_nxt_s       = 1'b1;
          state_nxt_s    = ST_GAP;
        end else if (bus.i_tick) begin
          unit_cnt_nxt_s = unit_cnt_r - 5'd1;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (bus.i_tick && (gap_cnt_r <= 5'd1)) begin
          gap_cnt_nxt_s = 5'd0;
          s3_nxt_s      = 1'b0;
          s7_nxt_s      = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else if (bus.i_tick) begin
          gap_cnt_nxt_s = gap_cnt_r - 5'd1;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters, gap flags and the latched pattern
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      unit_cnt_r <= '0;
      gap_cnt_r  <= '0;
      s3_r       <= 1'b0;
      s7_r       <= 1'b0;
      bad_r      <= 1'b0;
      pattern_r  <= '0;
      len_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      unit_cnt_r <= unit_cnt_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      s3_r       <= s3_nxt_s;
      s7_r       <= s7_nxt_s;
      bad_r      <= bad_nxt_s;
      if (load_s) begin
        pattern_r <= enc_pattern_s;
        len_r     <= enc_len_s;
      end
    end
  end

  assign bus.o_full       = full_s;
  assign bus.o_morse_code = pattern_r;
  assign bus.o_read       = (state_r == ST_LOAD);
  assign bus.o_busy       = (state_r != ST_IDLE);
  assign bus.o_s3         = s3_r;
  assign bus.o_s7         = s7_r;
  assign bus.o_bad_char   = bad_r;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed and random character streams checked against
// a dot/dash string model of the expected load, send and gap unit runs.
module tb_morse_sequencer;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_SEND = 2;
  localparam int P_S3   = 3;
  localparam int P_S7   = 4;

  logic clk;
  logic rst;

  morse_sequencer_if bus();

  morse_sequencer #(.DEPTH(8), .GAP_CHAR(3), .GAP_WORD(7)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits [10]  = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

  int          checks;
  int          errors;
  int          obs_runs [$];
  int          exp_runs [$];
  logic [19:0] obs_pat [$];
  logic [19:0] exp_pat [$];
  int          obs_bad;
  int          exp_bad;
  int          last_ph;
  bit          brk;
  logic        last_read;
  int          tcnt;
  bit          rand_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify();
    if (bus.o_read) return P_LOAD;
    else if (bus.o_s3) return P_S3;
    else if (bus.o_s7) return P_S7;
    else if (bus.o_busy) return P_SEND;
    else return P_IDLE;
  endfunction

  // A tick consumed at a clock edge belongs to the phase seen just before that edge
  task automatic account(input int ph);
    if (ph == P_IDLE) begin
      brk = 1'b1;
    end else if (!brk && obs_runs.size() > 0 && (obs_runs[obs_runs.size()-1] / 64) == ph) begin
      obs_runs[obs_runs.size()-1] = obs_runs[obs_runs.size()-1] + 1;
    end else begin
      obs_runs.push_back(ph * 64 + 1);
      brk = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.i_tick) account(last_ph);
    if (bus.o_read && !last_read) obs_pat.push_back(bus.o_morse_code);
    if (bus.o_bad_char) obs_bad++;
    last_read = bus.o_read;
    last_ph   = classify();
    tcnt        = (tcnt + 1) % 4;
    bus.i_tick  = (tcnt == 3);
    if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_char(input logic [7:0] c);
    logic [7:0]  u;
    string       m;
    string       bits;
    logic [19:0] pat;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    m = "";
    if (u >= 8'h41 && u <= 8'h5a) m = letters[u - 8'h41];
    else if (u >= 8'h30 && u <= 8'h39) m = digits[u - 8'h30];
    if (m.len() > 0) begin
      bits = "";
      for (int i = 0; i < m.len(); i++) begin
        if (i > 0) bits = {bits, "0"};
        bits = (m[i] == "-") ? {bits, "111"} : {bits, "1"};
      end
      pat = '0;
      for (int j = 0; j < bits.len(); j++) pat[19-j] = (bits[j] == "1");
      exp_pat.push_back(pat);
      exp_runs.push_back(P_LOAD * 64 + 1);
      exp_runs.push_back(P_SEND * 64 + bits.len());
      exp_runs.push_back(P_S3 * 64 + 3);
    end else if (u == 8'h20) begin
      exp_runs.push_back(P_S7 * 64 + 4);
    end else begin
      exp_bad++;
    end
  endtask

  task automatic clear_model();
    obs_runs.delete();
    exp_runs.delete();
    obs_pat.delete();
    exp_pat.delete();
    obs_bad = 0;
    exp_bad = 0;
    brk     = 1'b1;
  endtask

  task automatic write_char(input logic [7:0] c);
    int guard;
    guard = 0;
    while (bus.o_full && guard < 2000) begin
      step();
      guard++;
    end
    check("write_wait", (guard < 2000) ? 32'd1 : 32'd0, 32'd1);
    bus.i_char  = c;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      write_char(s[i]);
      model_char(s[i]);
    end
  endtask

  task automatic drain();
    int budget;
    int quiet;
    budget      = 0;
    quiet       = 0;
    rand_ready  = 1'b0;
    bus.i_ready = 1'b1;
    while ((obs_pat.size() < exp_pat.size() || obs_bad < exp_bad || quiet < 12) && budget < 8000) begin
      step();
      budget++;
      quiet = (bus.o_busy || bus.o_read || bus.o_bad_char) ? 0 : quiet + 1;
    end
    check("drain_done", (budget < 8000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_nruns"}, obs_runs.size(), exp_runs.size());
    for (int i = 0; i < exp_runs.size() && i < obs_runs.size(); i++)
      check($sformatf("%s_run%0d", tag, i), obs_runs[i], exp_runs[i]);
    check({tag, "_npat"}, obs_pat.size(), exp_pat.size());
    for (int i = 0; i < exp_pat.size() && i < obs_pat.size(); i++)
      check($sformatf("%s_pat%0d", tag, i), obs_pat[i], exp_pat[i]);
    check({tag, "_bad"}, obs_bad, exp_bad);
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return 8'(8'h41 + $urandom_range(0, 25));
      4:          return 8'(8'h61 + $urandom_range(0, 25));
      5, 6:       return 8'(8'h30 + $urandom_range(0, 9));
      7, 8:       return 8'h20;
      default:    return 8'(8'h21 + $urandom_range(0, 14));
    endcase
  endfunction

  initial begin
    logic [7:0] c;
    int         n;
    int         guard;
    string      fill_str;

    checks = 0; errors = 0;
    rst = 1'b1;
    bus.i_tick = 1'b0; bus.i_char = 8'h00; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    tcnt = 0; last_ph = P_IDLE; last_read = 1'b0; rand_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);

    check("rst_read", bus.o_read, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_s3", bus.o_s3, 0);
    check("rst_s7", bus.o_s7, 0);
    check("rst_bad", bus.o_bad_char, 0);
    check("rst_code", bus.o_morse_code, 0);
    check("rst_full", bus.o_full, 0);

    rst = 1'b0;
    bus.i_ready = 1'b1;
    step(); step();
    check("idle_busy", bus.o_busy, 0);

    clear_model(); write_str("E"); drain(); compare("E");
    check("E_code", (obs_pat.size() > 0) ? obs_pat[0] : 20'h0, 20'h80000);

    clear_model(); write_str("A S"); drain(); compare("AS");
    check("A_code", (obs_pat.size() > 0) ? obs_pat[0] : 20'h0, 20'hB8000);
    check("S_code", (obs_pat.size() > 1) ? obs_pat[1] : 20'h0, 20'hA8000);

    clear_model(); write_str("0a"); drain(); compare("zero_a");
    check("zero_code", (obs_pat.size() > 0) ? obs_pat[0] : 20'h0, 20'hEEEEE);
    check("lower_a_code", (obs_pat.size() > 1) ? obs_pat[1] : 20'h0, 20'hB8000);

    clear_model(); write_str("#"); drain(); compare("hash");
    check("hash_full", bus.o_full, 0);

    // Fill the FIFO while the blinker is not ready, then overflow by one
    clear_model();
    bus.i_ready = 1'b0;
    fill_str = "HELLOW0R";
    for (int i = 0; i < 8; i++) begin
      write_char(fill_str[i]);
      model_char(fill_str[i]);
      if (i == 6) check("full_after7", bus.o_full, 0);
    end
    check("full_after8", bus.o_full, 1);
    bus.i_char = 8'h51; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    check("full_reject", bus.o_full, 1);
    drain(); compare("fill");

    // Reset in the middle of sending '0' with more characters queued
    clear_model();
    write_str("0");
    guard = 0;
    while (classify() != P_SEND && guard < 400) begin step(); guard++; end
    check("reach_send", (guard < 400) ? 32'd1 : 32'd0, 32'd1);
    write_char(8'h45); write_char(8'h54);
    repeat (6) step();
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_read", bus.o_read, 0);
    check("mid_rst_code", bus.o_morse_code, 0);
    check("mid_rst_full", bus.o_full, 0);
    check("mid_rst_s3s7", {bus.o_s3, bus.o_s7}, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    clear_model();
    write_str("E"); drain(); compare("post_rst");

    for (int r = 0; r < 6; r++) begin
      clear_model();
      rand_ready = 1'b1;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        c = rand_char();
        write_char(c);
        model_char(c);
        repeat ($urandom_range(0, 3)) step();
      end
      drain();
      compare($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
